wb_host_master: RTL and testbench

Wishbone classic-cycle initiator that drives the user-area Wishbone slave port from a simple command/response stream. It lets an on-chip or test-harness source, such as a logic-analyzer sequencer or a future UART bridge, select projects and write project registers without the management core. It accepts one command at a time, runs a single Wishbone cycle, waits for ack with a bounded timeout, and returns read data or an error flag.

---
 rtl/wb_host_pkg.sv | 20 ++
 rtl/wb_host_master.sv | 111 +++++++++++
 tb/tb_wb_host_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_host_pkg.sv
// rtl/wb_host_pkg.sv - shared types and constants for the Wishbone host master
`timescale 1ns/1ps
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  localparam int          TIMEOUT_CYCLES_DEF = 255;
  localparam logic [31:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;

  // Harness register map on the user-area Wishbone port
  localparam logic [31:0] ADR_SELECT = 32'h3000_0000;
  localparam logic [31:0] ADR_WS2812 = 32'h3000_0100;
  localparam logic [31:0] ADR_7SEG   = 32'h3000_0200;
  localparam logic [31:0] ADR_FREQ   = 32'h3000_0400;

endpackage

// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - single-outstanding Wishbone classic initiator fed by a cmd/rsp stream
// Optional ack timeout and error response enabled by WBM_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  wbm_state_t state, state_next;
  logic       we_q;
  logic       tmo_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = BUS;
      BUS:     if (wbm_ack_i || tmo_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign wbm_cyc_o = (state == BUS);
  assign wbm_stb_o = (state == BUS);
  assign wbm_we_o  = we_q && (state == BUS);

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      rsp_dat   <= 32'h0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        we_q      <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
      end
      // Ack has priority over a timeout landing in the same cycle
      if (state == BUS) begin
        if (wbm_ack_i)    rsp_dat <= we_q ? 32'h0 : wbm_dat_i;
        else if (tmo_hit) rsp_dat <= ERR_DATA;
      end
    end
  end

`ifdef WBM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;
  logic        rsp_err_q;

  assign tmo_hit = (state == BUS) && (tmo_cnt == TMO_LAST);
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt   <= 16'h0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) tmo_cnt <= 16'h0;
      else if (state == BUS)          tmo_cnt <= tmo_cnt + 16'h1;
      if (state == BUS) begin
        if (wbm_ack_i)    rsp_err_q <= 1'b0;
        else if (tmo_hit) rsp_err_q <= 1'b1;
      end
    end
  end
`else
  logic [15:0] unused_tmo_cycles;

  assign tmo_hit           = 1'b0;
  assign rsp_err           = 1'b0;
  assign unused_tmo_cycles = 16'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_wb_host_master.sv
// tb/tb_wb_host_master.sv - bench for wb_host_master with a registered-ack harness slave
`timescale 1ns/1ps
module tb_wb_host_master;
  import wb_host_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        busy;

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Harness slave: four registers, registered ack, no ack for unmapped addresses
  logic [31:0] hreg [4];
  logic        ack_q;
  logic [15:0] bc;
  logic        stub_mode;
  logic [15:0] stub_at;
  logic [31:0] stub_data;
  int          ridx;

  function automatic int reg_idx(input logic [31:0] a);
    if (a == ADR_SELECT) return 0;
    if (a == ADR_WS2812) return 1;
    if (a == ADR_7SEG)   return 2;
    if (a == ADR_FREQ)   return 3;
    return -1;
  endfunction

  always_comb ridx = reg_idx(wbm_adr_o);

  always @(posedge clk) begin
    bc <= wbm_cyc_o ? bc + 16'h1 : 16'h0;
    if (reset) ack_q <= 1'b0;
    else       ack_q <= wbm_cyc_o && wbm_stb_o && !ack_q && !stub_mode && (ridx >= 0);
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && !ack_q && !stub_mode && (ridx >= 0))
      for (int b = 0; b < 4; b++)
        if (wbm_sel_o[b]) hreg[ridx][b*8 +: 8] <= wbm_dat_o[b*8 +: 8];
  end

  assign wbm_ack_i = stub_mode ? (wbm_cyc_o && bc == stub_at) : ack_q;
  assign wbm_dat_i = stub_mode ? stub_data : ((ridx >= 0) ? hreg[ridx] : 32'h0);

  // Bus monitor: request fields must not move while cyc is high
  logic        prev_cyc = 1'b0;
  logic [68:0] snap;
  int          stab_err = 0;
  int          cyc_len = 0;
  int          last_cyc_len = 0;

  always @(negedge clk) begin
    if (wbm_cyc_o) begin
      if (!prev_cyc) begin
        snap    = {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};
        cyc_len = 1;
      end else begin
        cyc_len++;
        if ({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== snap) stab_err++;
      end
      if (wbm_stb_o !== 1'b1) stab_err++;
    end else if (prev_cyc) begin
      last_cyc_len = cyc_len;
    end
    prev_cyc = wbm_cyc_o;
  end

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp_dat;
    int          hold;
  } vec_t;
  vec_t vt [10];

  task automatic check_reset_vals(input string tag);
    check32({tag, "_cyc"},   32'(wbm_cyc_o), 32'd0);
    check32({tag, "_stb"},   32'(wbm_stb_o), 32'd0);
    check32({tag, "_we"},    32'(wbm_we_o),  32'd0);
    check32({tag, "_sel"},   32'(wbm_sel_o), 32'd0);
    check32({tag, "_adr"},   wbm_adr_o,      32'd0);
    check32({tag, "_dato"},  wbm_dat_o,      32'd0);
    check32({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    check32({tag, "_rspd"},  rsp_dat,        32'd0);
    check32({tag, "_rspe"},  32'(rsp_err),   32'd0);
    check32({tag, "_cmdr"},  32'(cmd_ready), 32'd1);
    check32({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  task automatic do_cmd(input string name, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp_dat, input logic exp_err,
                        input int exp_lat, input int hold);
    rsp_t e;
    int   lat;
    int   bad;
    logic [31:0] held;
    @(negedge clk);
    check32({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    e.dat = exp_dat; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check32({name, "_lat"}, lat, exp_lat);
    e = sb.pop_front();
    check32({name, "_dat"}, rsp_dat, e.dat);
    check32({name, "_err"}, 32'(rsp_err), 32'(e.err));
    if (hold > 0) begin
      bad  = 0;
      held = rsp_dat;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_dat !== held || cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
      check32({name, "_backpressure"}, bad, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check32({name, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check32({name, "_rspv_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wait_cycles;
    logic rv_seen;

    vt[0] = '{1'b1, 4'hF, ADR_SELECT, 32'h0000_0002, 32'h0000_0000, 0};
    vt[1] = '{1'b0, 4'hF, ADR_SELECT, 32'h0000_0000, 32'h0000_0002, 0};
    vt[2] = '{1'b1, 4'hF, ADR_WS2812, 32'h00A1_B2C3, 32'h0000_0000, 0};
    vt[3] = '{1'b0, 4'hF, ADR_WS2812, 32'h0000_0000, 32'h00A1_B2C3, 10};
    vt[4] = '{1'b1, 4'h3, ADR_7SEG,   32'h1234_5678, 32'h0000_0000, 0};
    vt[5] = '{1'b0, 4'hF, ADR_7SEG,   32'hFFFF_FFFF, 32'h0000_5678, 0};
    vt[6] = '{1'b1, 4'hC, ADR_7SEG,   32'hAABB_CCDD, 32'h0000_0000, 0};
    vt[7] = '{1'b0, 4'hF, ADR_7SEG,   32'h0000_0000, 32'hAABB_5678, 0};
    vt[8] = '{1'b1, 4'hF, ADR_FREQ,   32'hCAFE_F00D, 32'h0000_0000, 0};
    vt[9] = '{1'b0, 4'hF, ADR_FREQ,   32'h0000_0000, 32'hCAFE_F00D, 0};

    for (int i = 0; i < 4; i++) hreg[i] = 32'h0;
    stub_mode = 1'b0; stub_at = 16'h0; stub_data = 32'h0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0;
    cmd_adr = 32'h0; cmd_dat = 32'h0; rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    for (int i = 0; i < 10; i++)
      do_cmd($sformatf("vec%0d", i), vt[i].we, vt[i].sel, vt[i].adr, vt[i].dat,
             vt[i].exp_dat, 1'b0, 3, vt[i].hold);

    check32("active_project", 32'(hreg[0][7:0]), 32'h02);
    check32("bus_stable", stab_err, 0);

`ifdef WBM_TIMEOUT_EN
    do_cmd("timeout", 1'b0, 4'hF, 32'h3000_0300, 32'h0, 32'hDEAD_BEEF, 1'b1, TMO + 1, 0);
    check32("timeout_cyc_len", last_cyc_len, TMO);
    wait_cycles = 3;
`else
    wait_cycles = 300;
`endif

    // Ack arrives exactly when the counter reaches its last value
    stub_mode = 1'b1; stub_at = 16'(TMO - 1); stub_data = 32'h5A5A_1234;
    do_cmd("ack_vs_tmo", 1'b0, 4'hF, 32'h3000_0300, 32'h0, 32'h5A5A_1234, 1'b0, TMO + 1, 0);
    check32("ack_vs_tmo_cyc_len", last_cyc_len, TMO);
    stub_mode = 1'b0;

    // Reset while stalled in BUS on an unmapped address
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'h5;
    cmd_adr = 32'h3000_0300; cmd_dat = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (wait_cycles - 1) @(negedge clk);
    check32("mid_cyc", 32'(wbm_cyc_o), 32'd1);
    check32("mid_we", 32'(wbm_we_o), 32'd1);
    check32("mid_rspv", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    rsp_ready = 1'b1;
    rv_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      rv_seen = rv_seen | rsp_valid | wbm_cyc_o;
    end
    rsp_ready = 1'b0;
    check32("no_rsp_after_reset", 32'(rv_seen), 32'd0);
    check32("bus_stable_final", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
